// File: rtl/bringup_sequencer_if.sv
// bringup_sequencer_if: status and control signals between the bring-up sequencer and the output path.
//   Lock and frame-status inputs, reset/enable outputs, and the debug state/retry count.
//   The master modport is the environment side that drives the inputs. The slave modport is the sequencer side.
interface bringup_sequencer_if;
   logic       pll54_locked;
   logic       pll_hdmi_locked;
   logic       output_fullcycle;
   logic       reset_dc_req;
   logic       pll_hdmi_areset;
   logic       video_nreset;
   logic       adv_enable;
   logic       dc_nreset_drive;
   logic       ready;
   logic [2:0] state;
   logic [7:0] retry_count;
   modport master (
      output pll54_locked, pll_hdmi_locked, output_fullcycle, reset_dc_req,
      input  pll_hdmi_areset, video_nreset, adv_enable, dc_nreset_drive, ready, state, retry_count
   );
   modport slave (
      input  pll54_locked, pll_hdmi_locked, output_fullcycle, reset_dc_req,
      output pll_hdmi_areset, video_nreset, adv_enable, dc_nreset_drive, ready, state, retry_count
   );
endinterface

// File: rtl/bringup_sequencer.sv
// bringup_sequencer: deterministic bring-up and recovery of the HDMI output path, plus the Dreamcast reset pulse.
//   clock, nreset (synchronous, active low) are plain ports. All other signals travel on bus (bringup_sequencer_if.slave):
//   lock and frame inputs, the DC reset request, the PLL/video/ADV/DC reset and enable outputs, and the ready, state and retry_count status.
//   When BRINGUP_LOCKLOSS_DCRESET_EN is defined, a pll54 lock loss in VIDEO or RUN also fires a DC reset pulse.
module bringup_sequencer #(
   parameter int unsigned PLL_RESET_CYCLES    = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 80_000,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 8_000_000,
   parameter int unsigned DC_RESET_CYCLES     = 8_000_000
) (
   input logic                 clock,
   input logic                 nreset,
   bringup_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {PLLRESET = 3'd0, WAIT_LOCK = 3'd1, VIDEO = 3'd2, RUN = 3'd3} state_t;
   localparam logic [31:0] PLL_LAST    = 32'(PLL_RESET_CYCLES - 1);
   localparam logic [31:0] STABLE_LAST = 32'(LOCK_STABLE_CYCLES - 1);
   localparam logic [31:0] TMO_LAST    = 32'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [31:0] DC_LOAD     = 32'(DC_RESET_CYCLES);
   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, tmo_q, tmo_d, dc_q, dc_d;
   logic [7:0]  retry_q, retry_d;
   logic        areset_q, vnrst_q, run_q, dcn_q;
   logic        locked, dc_trig;
   assign locked = bus.pll54_locked && bus.pll_hdmi_locked;
   // cnt_q is the dwell counter in PLLRESET and the consecutive-lock counter in WAIT_LOCK
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      retry_d = retry_q;
      case (state_q)
         PLLRESET: begin
            tmo_d = '0;
            cnt_d = (cnt_q == PLL_LAST) ? '0 : cnt_q + 32'd1;
            if (cnt_q == PLL_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            cnt_d = locked ? cnt_q + 32'd1 : '0;
            tmo_d = tmo_q + 32'd1;
            // stable completion takes priority over a coincident timeout
            if (locked && cnt_q == STABLE_LAST) begin
               state_d = VIDEO;
               cnt_d   = '0;
               tmo_d   = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = PLLRESET;
               cnt_d   = '0;
               tmo_d   = '0;
               retry_d = retry_q + {7'd0, retry_q != 8'hff};
            end
         end
         VIDEO, RUN: begin
            cnt_d = '0;
            if (!locked) state_d = PLLRESET;
            else if (bus.output_fullcycle) state_d = RUN;
         end
         default: state_d = PLLRESET;
      endcase
   end
`ifdef BRINGUP_LOCKLOSS_DCRESET_EN
   assign dc_trig = bus.reset_dc_req || ((state_q == VIDEO || state_q == RUN) && !bus.pll54_locked);
`else
   assign dc_trig = bus.reset_dc_req;
`endif
   // a new trigger reloads the counter, so a request mid-pulse extends it
   assign dc_d = dc_trig ? DC_LOAD : dc_q - {31'd0, dc_q != '0};
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q  <= PLLRESET;
         cnt_q    <= '0;
         tmo_q    <= '0;
         dc_q     <= '0;
         retry_q  <= '0;
         areset_q <= 1'b1;
         vnrst_q  <= 1'b0;
         run_q    <= 1'b0;
         dcn_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         dc_q     <= dc_d;
         retry_q  <= retry_d;
         areset_q <= state_d == PLLRESET;
         vnrst_q  <= state_d == VIDEO || state_d == RUN;
         run_q    <= state_d == RUN;
         dcn_q    <= dc_d == '0;
      end
   end
   assign bus.pll_hdmi_areset = areset_q;
   assign bus.video_nreset    = vnrst_q;
   assign bus.adv_enable      = run_q;
   assign bus.ready           = run_q;
   assign bus.dc_nreset_drive = dcn_q;
   assign bus.state           = state_q;
   assign bus.retry_count     = retry_q;
endmodule

// File: tb/tb_bringup_sequencer.sv
// tb_bringup_sequencer: vector table, directed corner sequences and a random run against a timestamp-based reference model.
module tb_bringup_sequencer;
   localparam int P  = 4;
   localparam int S  = 8;
   localparam int T  = 64;
   localparam int DC = 16;
`ifdef BRINGUP_LOCKLOSS_DCRESET_EN
   localparam bit LL_DC_EN = 1'b1;
`else
   localparam bit LL_DC_EN = 1'b0;
`endif
   logic clock = 1'b0;
   logic nreset;
   int   tests = 0;
   int   fails = 0;
   always #5 clock = ~clock;
   bringup_sequencer_if bus();
   bringup_sequencer #(
      .PLL_RESET_CYCLES(P), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T), .DC_RESET_CYCLES(DC)
   ) dut (
      .clock(clock),
      .nreset(nreset),
      .bus(bus)
   );
   logic [15:0] got;
   assign got = {bus.pll_hdmi_areset, bus.video_nreset, bus.adv_enable, bus.ready,
                 bus.dc_nreset_drive, bus.state, bus.retry_count};
   // reference model: phase plus the edge index it was entered on, lock run length, pulse end time
   int m_n = 0, m_state = 0, m_enter = 0, m_run = 0, m_retry = 0, m_dc_end = 0;
   task automatic model_step(input logic nr, p54, ph, full, req);
      logic lk;
      lk = p54 && ph;
      m_n++;
      if (!nr) begin
         m_state = 0; m_enter = m_n; m_run = 0; m_retry = 0; m_dc_end = m_n;
         return;
      end
      if (req || (LL_DC_EN && m_state >= 2 && !p54)) m_dc_end = m_n + DC;
      case (m_state)
         0: if (m_n - m_enter == P) begin m_state = 1; m_enter = m_n; m_run = 0; end
         1: begin
            m_run = lk ? m_run + 1 : 0;
            if (m_run == S) begin m_state = 2; m_enter = m_n; end
            else if (m_n - m_enter == T) begin
               m_state = 0; m_enter = m_n;
               if (m_retry < 255) m_retry++;
            end
         end
         default: if (!lk) begin m_state = 0; m_enter = m_n; end else if (full) m_state = 3;
      endcase
   endtask
   function automatic logic [15:0] m_exp();
      return {m_state == 0, m_state >= 2, m_state == 3, m_state == 3, !(m_n < m_dc_end), 3'(m_state), 8'(m_retry)};
   endfunction
   function automatic logic [15:0] ev(input logic ar, vn, adv, dcn, input int st, rt);
      return {ar, vn, adv, adv, dcn, 3'(st), 8'(rt)};
   endfunction
   task automatic tick(input logic nr, p54, ph, full, req);
      nreset = nr;
      bus.pll54_locked = p54;
      bus.pll_hdmi_locked = ph;
      bus.output_fullcycle = full;
      bus.reset_dc_req = req;
      @(posedge clock);
      model_step(nr, p54, ph, full, req);
      #1;
   endtask
   task automatic check(input string name, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   typedef struct {
      int          cyc;
      logic        nr, p54, ph, full, req;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[16];
   initial begin
      nreset = 1'b0;
      bus.pll54_locked = 1'b0;
      bus.pll_hdmi_locked = 1'b0;
      bus.output_fullcycle = 1'b0;
      bus.reset_dc_req = 1'b0;
      tbl[0]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, 1, 0, 0)};
      tbl[1]  = '{3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, 1, 0, 0)};
      tbl[2]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 1, 1, 0)};
      tbl[3]  = '{7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, 1, 1, 0)};
      tbl[4]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 1, 0, 1, 2, 0)};
      tbl[5]  = '{3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 1, 0, 1, 2, 0)};
      tbl[6]  = '{1,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ev(0, 1, 1, 1, 3, 0)};
      tbl[7]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 1, 1, 1, 3, 0)};
      tbl[8]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ev(0, 1, 1, 0, 3, 0)};
      tbl[9]  = '{15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 1, 1, 0, 3, 0)};
      tbl[10] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 1, 1, 1, 3, 0)};
      tbl[11] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, !LL_DC_EN, 0, 0)};
      tbl[12] = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(1, 0, 0, !LL_DC_EN, 0, 0)};
      tbl[13] = '{3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ev(0, 0, 0, !LL_DC_EN, 1, 0)};
      tbl[14] = '{64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev(1, 0, 0, 1, 0, 1)};
      tbl[15] = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 1, 1, 1)};
      for (int i = 0; i < 16; i++) begin
         repeat (tbl[i].cyc) tick(tbl[i].nr, tbl[i].p54, tbl[i].ph, tbl[i].full, tbl[i].req);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end
      // glitchy lock: one low cycle after 5 stable cycles restarts the stable count
      repeat (2) tick(0, 1, 1, 0, 0);
      repeat (4) tick(1, 1, 1, 0, 0);
      check("glitch_wait_entry", ev(0, 0, 0, 1, 1, 0));
      repeat (5) tick(1, 1, 1, 0, 0);
      tick(1, 1, 0, 0, 0);
      check("glitch_low", ev(0, 0, 0, 1, 1, 0));
      repeat (7) tick(1, 1, 1, 0, 0);
      check("glitch_restart", ev(0, 0, 0, 1, 1, 0));
      tick(1, 1, 1, 0, 0);
      check("glitch_video", ev(0, 1, 0, 1, 2, 0));
      // timeouts and retry saturation
      repeat (2) tick(0, 0, 0, 0, 0);
      repeat (3 * (P + T)) tick(1, 0, 0, 0, 0);
      check("retry_3", ev(1, 0, 0, 1, 0, 3));
      repeat (297 * (P + T)) tick(1, 0, 0, 0, 0);
      check("retry_255", ev(1, 0, 0, 1, 0, 255));
      repeat (P + T) tick(1, 0, 0, 0, 0);
      check("retry_sat", ev(1, 0, 0, 1, 0, 255));
      // DC retrigger while in RUN
      repeat (2) tick(0, 1, 1, 0, 0);
      repeat (P + S) tick(1, 1, 1, 0, 0);
      tick(1, 1, 1, 1, 0);
      check("run_reached", ev(0, 1, 1, 1, 3, 0));
      for (int c = 0; c <= 26; c++) begin
         tick(1, 1, 1, 0, c == 0 || c == 10);
         check($sformatf("dc_retrig_t%0d", c + 1), ev(0, 1, 1, c >= 26, 3, 0));
      end
      // reset in the middle of a DC pulse
      tick(1, 1, 1, 0, 1);
      for (int c = 1; c <= 4; c++) tick(1, 1, 1, 0, 0);
      check("midpulse_low", ev(0, 1, 1, 0, 3, 0));
      tick(0, 1, 1, 0, 0);
      check("midpulse_reset", ev(1, 0, 0, 1, 0, 0));
      // random run against the model
      tick(0, 1, 1, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         tick($urandom_range(0, 499) != 0, $urandom_range(0, 29) != 0, $urandom_range(0, 29) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
         check($sformatf("rand%0d", i), m_exp());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bringup_sequencer.md
# bringup_sequencer

Control-clock-domain sequencer that owns bring-up and recovery of the output path. It holds the HDMI PLL in reset, waits for both PLLs to lock stably, and releases the ram2video/output reset. It then enables the ADV7513 configurator once the output has completed a full frame, and generates the stretched Dreamcast reset pulse. It replaces the scattered lock-loss edge detectors and free-running reset counter at top level with one deterministic state machine.

## Interface
Parameters:
- PLL_RESET_CYCLES, 16, cycles pll_hdmi_areset is held high per attempt (>=1)
- LOCK_STABLE_CYCLES, 80_000, consecutive cycles both locks must be high before release (>=1)
- LOCK_TIMEOUT_CYCLES, 8_000_000, max cycles in WAIT_LOCK before retrying PLL reset (> LOCK_STABLE_CYCLES)
- DC_RESET_CYCLES, 8_000_000, Dreamcast reset low time (~100 ms @ 80 MHz) (>=1)

Ports:
- clock  in  1  control clock; single clock domain; all inputs are pre-synchronized to it
- nreset  in  1  synchronous, active-low reset
- pll54_locked  in  1  54 MHz PLL lock
- pll_hdmi_locked  in  1  HDMI PLL lock
- output_fullcycle  in  1  level; high once ram2video has emitted one complete frame
- reset_dc_req  in  1  single-cycle Dreamcast reset request (from i2c, after CDC)
- pll_hdmi_areset  out  1  HDMI PLL reset request (ORed into reconfig pll_areset_in)
- video_nreset  out  1  active-low reset for ram2video / output path
- adv_enable  out  1  output_ready for ADV7513 configurator
- dc_nreset_drive  out  1  0 = pull DC_NRESET low; 1 = release (top level tristates)
- ready  out  1  high only in RUN
- state  out  3  current state encoding, for the status/debug register
- retry_count  out  8  saturating count of lock timeouts since reset

## Operation
- States (encoding): PLLRESET=0, WAIT_LOCK=1, VIDEO=2, RUN=3.
- PLLRESET: pll_hdmi_areset=1, video_nreset=0, adv_enable=0. After PLL_RESET_CYCLES cycles in the state -> WAIT_LOCK, counter cleared.
- WAIT_LOCK: pll_hdmi_areset=0. Stable counter increments while pll54_locked && pll_hdmi_locked, clears to 0 on any cycle either is low. Reaching LOCK_STABLE_CYCLES -> VIDEO. A separate timeout counter reaching LOCK_TIMEOUT_CYCLES -> PLLRESET, retry_count+1 (saturates at 255). Stable completion and timeout on the same cycle: stable wins.
- VIDEO: video_nreset=1. output_fullcycle high -> RUN.
- RUN: adv_enable=1, ready=1.
- Lock loss: in VIDEO or RUN, either lock low for one cycle -> PLLRESET next cycle; video_nreset and adv_enable drop with the state change.
- Dreamcast reset channel, independent of the state machine: reset_dc_req loads a 32-bit down-counter with DC_RESET_CYCLES and drives dc_nreset_drive=0. The output returns to 1 when the counter reaches 0. A request during an active pulse reloads the counter (retrigger, pulse extended). No pulse is generated at power-up.
- Counters are 32-bit unsigned; comparisons use ==, no wrap is reachable in any state.

## Timing
- Reset values (nreset=0 at clock edge): state=PLLRESET, pll_hdmi_areset=1, video_nreset=0, adv_enable=0, ready=0, dc_nreset_drive=1, retry_count=0, all counters 0.
- All outputs registered; one-cycle latency from input sample to output change.
- PLLRESET duration exactly PLL_RESET_CYCLES cycles. Earliest release to VIDEO is PLL_RESET_CYCLES + LOCK_STABLE_CYCLES cycles after reset deassert.
- DC pulse: dc_nreset_drive low from the cycle after reset_dc_req for exactly DC_RESET_CYCLES cycles.
- nreset asserted mid-operation aborts any DC pulse, with dc_nreset_drive=1 on the next edge, and returns to PLLRESET.

## Configuration
- BRINGUP_LOCKLOSS_DCRESET_EN: when defined, entering PLLRESET from VIDEO or RUN due to pll54_locked loss also triggers a DC reset pulse, identical to a reset_dc_req. When undefined, lock loss never touches dc_nreset_drive.

## Test plan
Params PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, DC_RESET_CYCLES=16.
- Clean bring-up: both locks high from reset -> pll_hdmi_areset high 4 cycles, video_nreset rises 8 cycles later; output_fullcycle pulse -> adv_enable and ready high next cycle, state=3.
- Glitchy lock: pll_hdmi_locked low for 1 cycle after 5 stable cycles -> stable count restarts, VIDEO entered 8 cycles after the glitch ends.
- Timeout: locks held low -> PLLRESET re-entered every 4+64 cycles; retry_count reads 3 after three timeouts; saturates at 255 after 300 timeouts.
- Lock loss in RUN: pll54_locked low 1 cycle -> next cycle state=0, video_nreset=0, adv_enable=0. With BRINGUP_LOCKLOSS_DCRESET_EN, dc_nreset_drive is also low for 16 cycles.
- DC reset retrigger: reset_dc_req at t=0 and t=10 -> dc_nreset_drive low from t=1 through t=26, high at t=27; state machine unaffected.
- Mid-pulse reset: nreset low at t=5 of a DC pulse -> dc_nreset_drive=1 and state=0 on the next edge.
